// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM stage: control-bus bit positions, access sizes
// and the alignment rule used by both the store path and the WB flag.
package mips_mem_pkg;

  localparam int MEM_READ_BIT  = 4;
  localparam int MEM_WRITE_BIT = 3;
  localparam int SIZE_MSB      = 2;
  localparam int SIZE_LSB      = 1;
  localparam int UNSIGNED_BIT  = 0;
  localparam int REGWRITE_BIT  = 1;
  localparam int MEMTOREG_BIT  = 0;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  // Reserved size 2'b10 falls into the word rule.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return |off;
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/seg_memory_access_if.sv
// EX/MEM inputs and MEM/WB outputs of the memory stage bundled as one bus.
interface seg_memory_access_if #(
  parameter int LEN         = 32,
  parameter int NB_ADDR     = 5,
  parameter int NB_CTRL_WB  = 2,
  parameter int NB_CTRL_MEM = 5
);
  logic [LEN-1:0]         i_ALU_result;
  logic [LEN-1:0]         i_write_data;
  logic [NB_ADDR-1:0]     i_write_register;
  logic [NB_CTRL_MEM-1:0] i_ctrl_mem_bus;
  logic [NB_CTRL_WB-1:0]  i_ctrl_wb_bus;
  logic [LEN-1:0]         o_read_data;
  logic [LEN-1:0]         o_ALU_result;
  logic [NB_ADDR-1:0]     o_write_register;
  logic [NB_CTRL_WB-1:0]  o_ctrl_wb_bus;
  logic                   o_misaligned;

  modport master (
    output i_ALU_result, i_write_data, i_write_register, i_ctrl_mem_bus, i_ctrl_wb_bus,
    input  o_read_data, o_ALU_result, o_write_register, o_ctrl_wb_bus, o_misaligned
  );

  modport slave (
    input  i_ALU_result, i_write_data, i_write_register, i_ctrl_mem_bus, i_ctrl_wb_bus,
    output o_read_data, o_ALU_result, o_write_register, o_ctrl_wb_bus, o_misaligned
  );
endinterface

// File: rtl/mem_data_ram.sv
// Dual-port data RAM: port A read-first with per-byte write enables, port B
// read-only. Both read ports are registered so the array maps onto block RAM.
module mem_data_ram #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_en_a,
  input  logic [NB_DATA/8-1:0] i_we_a,
  input  logic [NB_ADDR-1:0]   i_addr_a,
  input  logic [NB_DATA-1:0]   i_din_a,
  output logic [NB_DATA-1:0]   o_dout_a,
  input  logic [NB_ADDR-1:0]   i_addr_b,
  output logic [NB_DATA-1:0]   o_dout_b
);
  localparam int NB_BE = NB_DATA / 8;

  logic [NB_DATA-1:0] r_mem [2**NB_ADDR];
  logic [NB_DATA-1:0] r_dout_a;
  logic [NB_DATA-1:0] r_dout_b;

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < NB_BE; b++)
      if (i_we_a[b]) r_mem[i_addr_a][b*8 +: 8] <= i_din_a[b*8 +: 8];
  end

  // Non-blocking reads of r_mem see the pre-write word: read-first on both ports.
  always_ff @(posedge i_clk) begin
    if (i_reset)     r_dout_a <= '0;
    else if (i_en_a) r_dout_a <= r_mem[i_addr_a];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_dout_b <= '0;
    else         r_dout_b <= r_mem[i_addr_b];
  end

  assign o_dout_a = r_dout_a;
  assign o_dout_b = r_dout_b;
endmodule

// File: rtl/seg_memory_access.sv
// MEM stage plus MEM/WB register: steers stores onto RAM byte lanes, registers
// the RAM read as WB read data, then aligns and extends the loaded value.
module seg_memory_access
  import mips_mem_pkg::*;
#(
  parameter int LEN         = 32,
  parameter int NB_ADDR     = 5,
  parameter int NB_CTRL_WB  = 2,
  parameter int NB_CTRL_MEM = 5,
  parameter int NB_MEM_ADDR = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_flush,
  seg_memory_access_if.slave     bus,
  input  logic [NB_MEM_ADDR-1:0] i_debug_addr,
  output logic [LEN-1:0]         o_debug_data
);
  localparam int NB_BE = LEN / 8;

  logic [NB_MEM_ADDR-1:0] w_word_idx;
  logic [1:0]             w_off, w_size;
  logic                   w_rd, w_wr, w_uns, w_bad_align, w_mis, w_we_ok;
  logic [NB_BE-1:0]       w_be;
  logic [LEN-1:0]         w_wdata, w_ram_q, w_read_data;
  logic [7:0]             w_byte;
  logic [15:0]            w_half;

  logic [LEN-1:0]         r_alu;
  logic [NB_ADDR-1:0]     r_wreg;
  logic [NB_CTRL_WB-1:0]  r_wb;
  logic                   r_mis, r_rd, r_uns;
  logic [1:0]             r_off, r_size;

  assign w_word_idx  = bus.i_ALU_result[NB_MEM_ADDR+1:2];
  assign w_off       = bus.i_ALU_result[1:0];
  assign w_size      = bus.i_ctrl_mem_bus[SIZE_MSB:SIZE_LSB];
  assign w_rd        = bus.i_ctrl_mem_bus[MEM_READ_BIT];
  assign w_wr        = bus.i_ctrl_mem_bus[MEM_WRITE_BIT];
  assign w_uns       = bus.i_ctrl_mem_bus[UNSIGNED_BIT];
  assign w_bad_align = misaligned(w_size, w_off);
  assign w_mis       = w_bad_align & (w_rd | w_wr);
  assign w_we_ok     = i_enable & ~i_reset & ~i_flush & w_wr & ~w_bad_align;

  // Data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    w_be    = '1;
    w_wdata = bus.i_write_data;
    case (w_size)
      SZ_BYTE: begin
        w_be    = NB_BE'(1) << w_off;
        w_wdata = {NB_BE{bus.i_write_data[7:0]}};
      end
      SZ_HALF: begin
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata = {(NB_BE/2){bus.i_write_data[15:0]}};
      end
      default: ;
    endcase
    if (!w_we_ok) w_be = '0;
  end

  mem_data_ram #(
    .NB_DATA (LEN),
    .NB_ADDR (NB_MEM_ADDR)
  ) u_ram (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_en_a   (i_enable),
    .i_we_a   (w_be),
    .i_addr_a (w_word_idx),
    .i_din_a  (w_wdata),
    .o_dout_a (w_ram_q),
    .i_addr_b (i_debug_addr),
    .o_dout_b (o_debug_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset || (i_enable && i_flush)) begin
      r_alu  <= '0;
      r_wreg <= '0;
      r_wb   <= '0;
      r_mis  <= 1'b0;
      r_rd   <= 1'b0;
      r_uns  <= 1'b0;
      r_off  <= '0;
      r_size <= '0;
    end else if (i_enable) begin
      r_alu              <= bus.i_ALU_result;
      r_wreg             <= bus.i_write_register;
      r_wb               <= bus.i_ctrl_wb_bus;
      r_wb[REGWRITE_BIT] <= bus.i_ctrl_wb_bus[REGWRITE_BIT] & ~(w_rd & w_bad_align);
      r_wb[MEMTOREG_BIT] <= bus.i_ctrl_wb_bus[MEMTOREG_BIT];
      r_mis              <= w_mis;
      r_rd               <= w_rd;
      r_uns              <= w_uns;
      r_off              <= w_off;
      r_size             <= w_size;
    end
  end

  assign w_byte = w_ram_q[{r_off, 3'b000} +: 8];
  assign w_half = r_off[1] ? w_ram_q[31:16] : w_ram_q[15:0];

  always_comb begin
    w_read_data = '0;
    if (r_rd) begin
      case (r_size)
        SZ_BYTE: w_read_data = r_uns ? {{(LEN-8){1'b0}}, w_byte}
                                     : {{(LEN-8){w_byte[7]}}, w_byte};
        SZ_HALF: w_read_data = r_uns ? {{(LEN-16){1'b0}}, w_half}
                                     : {{(LEN-16){w_half[15]}}, w_half};
        default: w_read_data = w_ram_q;
      endcase
    end
  end

  assign bus.o_read_data      = w_read_data;
  assign bus.o_ALU_result     = r_alu;
  assign bus.o_write_register = r_wreg;
  assign bus.o_ctrl_wb_bus    = r_wb;
  assign bus.o_misaligned     = r_mis;
endmodule

// File: tb/tb_seg_memory_access.sv
// Directed bench for the MEM stage: a byte-level memory model predicts every
// registered output each cycle, plus hand-computed literal checks.
module tb_seg_memory_access;
  logic       clk = 1'b0;
  logic       rst, en, fl;
  logic [7:0] dbg_addr;
  logic [31:0] dbg_data;
  int total = 0;
  int bad   = 0;
  logic chk_on = 1'b0;

  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b11;

  always #5 clk = ~clk;

  seg_memory_access_if bus();

  seg_memory_access dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_enable     (en),
    .i_flush      (fl),
    .bus          (bus),
    .i_debug_addr (dbg_addr),
    .o_debug_data (dbg_data)
  );

  // Model state
  logic [31:0] m_mem [256];
  logic [31:0] e_rd, e_alu, e_dbg;
  logic [4:0]  e_wreg;
  logic [1:0]  e_wb;
  logic        e_mis, e_rd_ok;

  always @(posedge clk) begin
    logic [31:0] a, d, v, mask;
    logic [4:0]  c;
    int nb, off, wi;
    logic is_mis;
    if (rst) begin
      e_rd = 0; e_alu = 0; e_wreg = 0; e_wb = 0; e_mis = 0; e_dbg = 0; e_rd_ok = 1;
    end else begin
      e_dbg = m_mem[dbg_addr];
      if (en) begin
        if (fl) begin
          e_rd = 0; e_alu = 0; e_wreg = 0; e_wb = 0; e_mis = 0; e_rd_ok = 1;
        end else begin
          a = bus.i_ALU_result; d = bus.i_write_data; c = bus.i_ctrl_mem_bus;
          nb  = (c[2:1] == 2'b00) ? 1 : (c[2:1] == 2'b01) ? 2 : 4;
          off = int'(a % 4);
          wi  = int'((a / 4) % 256);
          is_mis = (int'(a % 32'(nb)) != 0);
          e_alu  = a;
          e_wreg = bus.i_write_register;
          e_mis  = (c[4] || c[3]) && is_mis;
          e_wb   = {bus.i_ctrl_wb_bus[1] && !(c[4] && is_mis), bus.i_ctrl_wb_bus[0]};
          e_rd_ok = !(c[4] && is_mis);
          if (c[4]) begin
            mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*nb)) - 1);
            v = (m_mem[wi] >> (8*off)) & mask;
            if (!c[0] && nb < 4 && v[8*nb-1]) v = v | ~mask;
            e_rd = v;
          end else e_rd = 0;
          if (c[3] && !is_mis)
            for (int i = 0; i < nb; i++) m_mem[wi][8*(off+i) +: 8] = d[8*i +: 8];
        end
      end
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      if (e_rd_ok && !$isunknown(e_rd)) cmp("model read_data", bus.o_read_data, e_rd);
      cmp("model ALU_result", bus.o_ALU_result, e_alu);
      cmp("model write_register", 32'(bus.o_write_register), 32'(e_wreg));
      cmp("model ctrl_wb", 32'(bus.o_ctrl_wb_bus), 32'(e_wb));
      cmp("model misaligned", 32'(bus.o_misaligned), 32'(e_mis));
      if (!$isunknown(e_dbg)) cmp("model debug_data", dbg_data, e_dbg);
    end
  end

  task automatic drv(input logic ien, ifl, irs, rd, wr, input logic [1:0] sz,
                     input logic uns, input logic [31:0] a, d, input logic [1:0] wb);
    en = ien; fl = ifl; rst = irs;
    bus.i_ctrl_mem_bus   = {rd, wr, sz, uns};
    bus.i_ALU_result     = a;
    bus.i_write_data     = d;
    bus.i_write_register = a[6:2] ^ 5'h01;
    bus.i_ctrl_wb_bus    = wb;
    @(posedge clk); @(negedge clk); #1;
  endtask

  task automatic st(input logic [1:0] sz, input logic [31:0] a, d);
    drv(1, 0, 0, 0, 1, sz, 0, a, d, 2'b00);
  endtask

  task automatic ld(input logic [1:0] sz, input logic uns, input logic [31:0] a);
    drv(1, 0, 0, 1, 0, sz, uns, a, 32'h0, 2'b11);
  endtask

  task automatic nop();
    drv(1, 0, 0, 0, 0, W, 0, 32'h0, 32'h0, 2'b00);
  endtask

  initial begin
    rst = 1; en = 0; fl = 0; dbg_addr = 0;
    bus.i_ALU_result = 0; bus.i_write_data = 0; bus.i_write_register = 0;
    bus.i_ctrl_mem_bus = 0; bus.i_ctrl_wb_bus = 0;
    drv(1, 0, 1, 0, 0, W, 0, 32'h0, 32'h0, 2'b00);
    chk_on = 1;
    drv(1, 1, 1, 1, 1, W, 0, 32'h10, 32'hFFFF_FFFF, 2'b11);
    cmp("reset read_data", bus.o_read_data, 32'h0);
    cmp("reset ALU_result", bus.o_ALU_result, 32'h0);
    cmp("reset ctrl_wb", 32'(bus.o_ctrl_wb_bus), 32'h0);
    cmp("reset misaligned", 32'(bus.o_misaligned), 32'h0);
    cmp("reset debug", dbg_data, 32'h0);

    for (int w = 0; w < 256; w++) st(W, 32'(w*4), 32'h0);

    st(W, 32'h10, 32'hDEAD_BEEF);
    ld(W, 0, 32'h10);
    cmp("lw deadbeef", bus.o_read_data, 32'hDEAD_BEEF);
    cmp("lw ctrl_wb", 32'(bus.o_ctrl_wb_bus), 32'h3);
    cmp("lw misaligned", 32'(bus.o_misaligned), 32'h0);

    st(W, 32'h10, 32'h0);
    st(B, 32'h13, 32'h1234_5680);
    ld(B, 0, 32'h13); cmp("lb 0x13", bus.o_read_data, 32'hFFFF_FF80);
    ld(B, 1, 32'h13); cmp("lbu 0x13", bus.o_read_data, 32'h0000_0080);
    ld(W, 0, 32'h10); cmp("lw after sb", bus.o_read_data, 32'h8000_0000);

    st(H, 32'h22, 32'hAAAA_BEEF);
    ld(H, 0, 32'h22); cmp("lh 0x22", bus.o_read_data, 32'hFFFF_BEEF);
    ld(H, 1, 32'h22); cmp("lhu 0x22", bus.o_read_data, 32'h0000_BEEF);
    st(H, 32'h21, 32'h0000_1234); cmp("sh misaligned flag", 32'(bus.o_misaligned), 32'h1);
    ld(W, 0, 32'h20); cmp("lw after bad sh", bus.o_read_data, 32'hBEEF_0000);
    ld(H, 0, 32'h21);
    cmp("lh misaligned wb", 32'(bus.o_ctrl_wb_bus), 32'h1);
    cmp("lh misaligned flag", 32'(bus.o_misaligned), 32'h1);
    drv(1, 0, 0, 1, 0, 2'b10, 0, 32'h20, 32'h0, 2'b11);
    cmp("reserved size as word", bus.o_read_data, 32'hBEEF_0000);
    st(W, 32'h12, 32'hFFFF_FFFF); cmp("sw misaligned flag", 32'(bus.o_misaligned), 32'h1);
    st(B, 32'h25, 32'h0000_0077);
    ld(W, 0, 32'h24); cmp("sb lane1", bus.o_read_data, 32'h0000_7700);

    ld(W, 0, 32'h10);
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, 0, 1, W, 0, 32'h34, 32'h1111_1111, 2'b00);
      cmp("stall alu held", bus.o_ALU_result, 32'h10);
      cmp("stall rd held", bus.o_read_data, 32'h8000_0000);
    end
    ld(W, 0, 32'h34); cmp("no write in stall", bus.o_read_data, 32'h0);
    drv(1, 1, 0, 0, 1, W, 0, 32'h30, 32'hFFFF_FFFF, 2'b11);
    cmp("flush alu", bus.o_ALU_result, 32'h0);
    cmp("flush wb", 32'(bus.o_ctrl_wb_bus), 32'h0);
    ld(W, 0, 32'h30); cmp("no write in flush", bus.o_read_data, 32'h0);
    drv(0, 1, 0, 1, 0, W, 0, 32'h10, 32'h0, 2'b11);
    cmp("flush ignored when stalled", bus.o_ALU_result, 32'h30);

    st(W, 32'h40, 32'h0102_0304);
    drv(1, 0, 0, 1, 1, W, 0, 32'h40, 32'h0A0B_0C0D, 2'b11);
    cmp("read-first old", bus.o_read_data, 32'h0102_0304);
    ld(W, 0, 32'h40); cmp("read-first new", bus.o_read_data, 32'h0A0B_0C0D);

    st(W, 32'h400, 32'h1234_5678);
    dbg_addr = 8'd0; nop();
    cmp("debug wrap", dbg_data, 32'h1234_5678);
    ld(W, 0, 32'h0); cmp("lw wrap", bus.o_read_data, 32'h1234_5678);
    st(W, 32'h404, 32'hA5A5_A5A5);
    dbg_addr = 8'd2; st(W, 32'h8, 32'hCCCC_CCCC);
    cmp("debug collision old", dbg_data, 32'h0);
    nop(); cmp("debug after write", dbg_data, 32'hCCCC_CCCC);
    dbg_addr = 8'd1; drv(0, 0, 0, 0, 0, W, 0, 32'h0, 32'h0, 2'b00);
    cmp("debug stalled w1", dbg_data, 32'hA5A5_A5A5);
    dbg_addr = 8'd0; drv(0, 0, 0, 0, 0, W, 0, 32'h0, 32'h0, 2'b00);
    cmp("debug stalled w0", dbg_data, 32'h1234_5678);

    ld(W, 0, 32'h10);
    drv(1, 0, 1, 1, 0, W, 0, 32'h10, 32'h0, 2'b11);
    cmp("mid reset rd", bus.o_read_data, 32'h0);
    cmp("mid reset alu", bus.o_ALU_result, 32'h0);
    cmp("mid reset wreg", 32'(bus.o_write_register), 32'h0);
    cmp("mid reset wb", 32'(bus.o_ctrl_wb_bus), 32'h0);
    cmp("mid reset dbg", dbg_data, 32'h0);
    dbg_addr = 8'd4; nop();
    cmp("ram kept after reset", dbg_data, 32'h8000_0000);
    ld(W, 0, 32'h40); cmp("lw after reset", bus.o_read_data, 32'h0A0B_0C0D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
